// File: rtl/mag_cook_timer.sv
// mag_cook_timer: BCD MM:SS microwave cook timer feeding timer_done to the magnetron controller.
// Define MAG_TIMER_BEEP_EN to add the beep output and its BEEP_TICKS parameter.
module mag_cook_timer #(
  parameter int TICK_DIV = 1000000
`ifdef MAG_TIMER_BEEP_EN
  , parameter int BEEP_TICKS = 3
`endif
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        clearn,
  input  logic        digit_valid,
  input  logic [3:0]  digit,
  input  logic        mag_on,
  output logic [15:0] time_bcd,
  output logic        running,
  output logic        timer_done
`ifdef MAG_TIMER_BEEP_EN
  , output logic      beep
`endif
);
  localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);
  typedef enum logic [1:0] {IDLE, ARMED, RUN, DONE} state_t;
  state_t        state_q, state_d;
  logic [15:0]   time_q, time_d, time_dec, key_time;
  logic [PW-1:0] pre_q, pre_d;
  logic          done_q, done_d, key;
  assign key      = digit_valid && digit <= 4'd9;
  assign key_time = state_q == DONE ? {12'h000, digit} : {time_q[11:0], digit};
  // Ripple borrow across the four digits; seconds above 59 just count down literally.
  always_comb begin
    time_dec = time_q;
    if (time_q[3:0] != 4'd0) time_dec[3:0] = time_q[3:0] - 4'd1;
    else begin
      time_dec[3:0] = 4'd9;
      if (time_q[7:4] != 4'd0) time_dec[7:4] = time_q[7:4] - 4'd1;
      else begin
        time_dec[7:4] = 4'd5;
        if (time_q[11:8] != 4'd0) time_dec[11:8] = time_q[11:8] - 4'd1;
        else begin
          time_dec[11:8]  = 4'd9;
          time_dec[15:12] = time_q[15:12] - 4'd1;
        end
      end
    end
  end
  always_comb begin
    state_d = state_q;
    time_d  = time_q;
    pre_d   = pre_q;
    done_d  = done_q;
    if (!clearn) begin
      state_d = IDLE;
      time_d  = 16'h0000;
      pre_d   = '0;
      done_d  = 1'b0;
    end else if (state_q == RUN) begin
      if (!mag_on) state_d = ARMED;
      else if (pre_q == PMAX) begin
        pre_d  = '0;
        time_d = time_dec;
        if (time_dec == 16'h0000) begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end else pre_d = pre_q + PW'(1);
    end else if (mag_on && state_q != DONE) begin
      state_d = state_q == IDLE ? DONE : RUN;
      done_d  = state_q == IDLE;
    end else if (key) begin
      time_d  = key_time;
      pre_d   = '0;
      done_d  = 1'b0;
      state_d = key_time != 16'h0000 ? ARMED : IDLE;
    end
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      time_q  <= 16'h0000;
      pre_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      time_q  <= time_d;
      pre_q   <= pre_d;
      done_q  <= done_d;
    end
  end
  assign time_bcd   = time_q;
  assign running    = state_q == RUN;
  assign timer_done = done_q;
`ifdef MAG_TIMER_BEEP_EN
  localparam int BN = BEEP_TICKS * TICK_DIV;
  localparam int BW = BN > 1 ? $clog2(BN) : 1;
  logic          beep_q, beep_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  // Counter holds remaining high cycles minus one; leaving DONE silences it at once.
  always_comb begin
    beep_d = beep_q;
    bcnt_d = bcnt_q;
    if (state_d != DONE) begin
      beep_d = 1'b0;
      bcnt_d = '0;
    end else if (state_q != DONE) begin
      beep_d = 1'b1;
      bcnt_d = BW'(BN - 1);
    end else if (bcnt_q == '0) beep_d = 1'b0;
    else bcnt_d = bcnt_q - BW'(1);
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      beep_q <= 1'b0;
      bcnt_q <= '0;
    end else begin
      beep_q <= beep_d;
      bcnt_q <= bcnt_d;
    end
  end
  assign beep = beep_q;
`endif
endmodule
